mb_rx_deser: RTL
================

// Module: mb_rx_deser
// PURPOSE
//  Mainband receive deserializer: downstream peer of the mainband TX serializer (16 data lanes, 64B flits).
//  Takes per-clk UI pairs from the DDR capture front end: 2 UI per lane per clk.
//  Checks the valid-lane framing, rebuilds 64-byte flits and queues them in a flit FIFO.
//  Drains via valid/ready to the logphy RX path. Single clock domain (fast clk); CDC handled elsewhere.
// PARAMETERS
//  FIFO_DEPTH  4   flit FIFO entries; power of 2, >=2
// PORTS
//  clk            in   1    fast clock (2GHz domain)
//  reset          in   1    reset, synchronous, active-high
//  rx_en_i        in   1    receiver enable; low forces IDLE and discards the partial flit
//  data_ui0_i     in   16   lane l, first (even) UI of this clk
//  data_ui1_i     in   16   lane l, second (odd) UI of this clk
//  valid_ui0_i    in   1    valid lane, even UI
//  valid_ui1_i    in   1    valid lane, odd UI
//  flit_o         out  512  head flit; byte k = flit_o[8k+7:8k]
//  flit_valid_o   out  1    FIFO non-empty
//  flit_ready_i   in   1    consumer accepts head when flit_valid_o=1
//  frame_err_o    out  1    1-cycle pulse on valid-framing violation
//  overflow_o     out  1    1-cycle pulse when a completed flit is dropped (FIFO full)
//  receiving_o    out  1    FSM in RECV
//  flit_count_o   out  16   flits pushed into FIFO, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: FSM=IDLE, cyc=0, frag=0, FIFO empty, assembly regs 0, all outputs 0 (flit_o=0).
//  Lane mapping, fragment f (0..3), cycle c (0..3) within fragment, lane l:
//   data_ui0_i[l] = byte(16f+l) bit 2c;  data_ui1_i[l] = byte(16f+l) bit 2c+1.
//   1 fragment = 4 clk (8 UI); 1 flit = 16 clk.
//  Valid framing per fragment: c0,c1 pair=11; c2,c3 pair=00 (4 UI high, 4 UI low).
//  FSM:
//   IDLE: pair 11 with rx_en_i=1 -> capture as f0 c0; go RECV, cyc=1.
//         pair 00 -> stay. Pair 01/10 -> frame_err_o pulse, stay IDLE.
//   RECV: each clk check pair vs framing (11 for cyc 0/1, 00 for cyc 2/3). Mismatch -> frame_err_o,
//         discard partial flit, go IDLE; the failing cycle is never used as a start.
//         cyc increments mod 4; at cyc=3, frag increments mod 4.
//         At f3 c3 (good): flit complete, push request. Stay RECV with cyc=0, frag=0
//         (back-to-back flits: next cycle must be pair 11, or pair 00 = idle gap).
//   In RECV at cyc=0, frag=0 (flit boundary), pair 00 -> IDLE, no error.
//   rx_en_i=0 in any state -> IDLE next cycle, partial flit discarded, no error pulse.
//  Latency: flit_valid_o/flit_o valid the clk after the f3 c3 sample (into empty FIFO).
//  FIFO: in-order; pop when flit_valid_o & flit_ready_i; flit_o = head (registered read).
//   Push accepted if count<FIFO_DEPTH or a pop occurs the same cycle.
//   Otherwise flit dropped, overflow_o pulse, FIFO and flit_count_o unchanged.
//   Pointers wrap mod FIFO_DEPTH; simultaneous push+pop keeps count.
//   flit_count_o increments only on an accepted push.
//  frame_err_o and overflow_o can pulse in the same cycle; they are independent.
//  Reset mid-operation: all state cleared next edge, queued flits lost.
// TESTING
//  1 Single flit, byte k=k, ready=1 -> flit_valid_o 1 clk after f3c3; flit_o byte k=k; count=1.
//  2 Three back-to-back flits (bytes k+16n), no gap -> 3 flits in order; no frame_err; count=3.
//  3 Valid pair 00 at f1 c1 -> frame_err_o 1 pulse, partial discarded;
//    following good flit (all 0xA5) received intact.
//  4 FIFO_DEPTH=4, ready=0, 5 flits -> 4 stored, overflow_o on 5th, count=4;
//    then ready=1 -> flits 0..3 in order.
//  5 reset at f2 c1 -> outputs 0 next clk; next flit (0x3C) correct; count=1.
//  6 rx_en_i=0 at f1 c2, then re-enabled -> no error, no flit;
//    next full flit received; pair 10 in IDLE -> frame_err_o pulse.

Source files
------------

// File: rtl/mb_rx_deser.sv
// Mainband receive deserializer: checks the valid-lane framing, rebuilds 64-byte flits from
// 2-UI-per-lane clk samples and queues them in a small flit FIFO drained by valid/ready.
module mb_rx_deser #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_en_i,
  input  logic [15:0]  data_ui0_i,
  input  logic [15:0]  data_ui1_i,
  input  logic         valid_ui0_i,
  input  logic         valid_ui1_i,
  output logic [511:0] flit_o,
  output logic         flit_valid_o,
  input  logic         flit_ready_i,
  output logic         frame_err_o,
  output logic         overflow_o,
  output logic         receiving_o,
  output logic [15:0]  flit_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [1:0]     cyc_q, cyc_d;
  logic [1:0]     frag_q, frag_d;
  logic [511:0]   asm_q, asm_d;
  logic [511:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [15:0]    fcnt_q, fcnt_d;
  logic           err_q, err_d;
  logic           ovf_q, ovf_d;
  logic           push, pop, push_ok;
  logic [1:0]     pair;

  // Bit (2c, 2c+1) of byte 16f+l lives at flat index {f, l, c, 0/1}.
  function automatic logic [511:0] capture_bits(input logic [511:0] cur, input logic [1:0] f,
                                                input logic [1:0] c, input logic [15:0] d0,
                                                input logic [15:0] d1);
    logic [511:0] r;
    logic [3:0]   l4;
    r = cur;
    for (int l = 0; l < 16; l++) begin
      l4 = 4'(l);
      r[{f, l4, c, 1'b0}] = d0[l];
      r[{f, l4, c, 1'b1}] = d1[l];
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cyc_q    <= 2'd0;
      frag_q   <= 2'd0;
      asm_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      fcnt_q   <= 16'd0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      frag_q   <= frag_d;
      asm_q    <= asm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  // The completed flit includes the f3 c3 sample, so the FIFO is written from asm_d.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= asm_d;
  end

  // Next-state: framing check, assembly and FIFO bookkeeping
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    frag_d  = frag_q;
    asm_d   = asm_q;
    err_d   = 1'b0;
    push    = 1'b0;
    pair    = {valid_ui0_i, valid_ui1_i};

    if (!rx_en_i) begin
      state_d = IDLE;
      cyc_d   = 2'd0;
      frag_d  = 2'd0;
    end else if (state_q == IDLE) begin
      if (pair == 2'b11) begin
        asm_d   = capture_bits(asm_q, 2'd0, 2'd0, data_ui0_i, data_ui1_i);
        state_d = RECV;
        cyc_d   = 2'd1;
        frag_d  = 2'd0;
      end else if (pair != 2'b00) begin
        err_d = 1'b1;
      end
    end else begin
      if (cyc_q == 2'd0 && frag_q == 2'd0 && pair == 2'b00) begin
        state_d = IDLE;
      end else if (pair == (cyc_q[1] ? 2'b00 : 2'b11)) begin
        asm_d = capture_bits(asm_q, frag_q, cyc_q, data_ui0_i, data_ui1_i);
        cyc_d = cyc_q + 2'd1;
        if (cyc_q == 2'd3) frag_d = frag_q + 2'd1;
        if (cyc_q == 2'd3 && frag_q == 2'd3) push = 1'b1;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
        cyc_d   = 2'd0;
        frag_d  = 2'd0;
      end
    end

    pop      = (cnt_q != '0) && flit_ready_i;
    push_ok  = push && ((cnt_q < DEPTH_C) || pop);
    ovf_d    = push && !push_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fcnt_d   = push_ok ? fcnt_q + 16'd1 : fcnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Outputs
  always_comb begin
    receiving_o  = (state_q == RECV);
    flit_valid_o = (cnt_q != '0);
    flit_o       = flit_valid_o ? mem_q[rd_ptr_q] : '0;
    flit_count_o = fcnt_q;
    frame_err_o  = err_q;
    overflow_o   = ovf_q;
  end

endmodule
